// File: rtl/opb_s2p_pkg.sv
// Shared constants and types for the Simulink-to-PPC snapshot register.
// Register word indices, status/control bit positions and handshake FSM states.
package opb_s2p_pkg;

    localparam int unsigned IDX_W = 6;

    localparam logic [IDX_W-1:0] IDX_DATA   = 6'd0;
    localparam logic [IDX_W-1:0] IDX_STATUS = 6'd1;
    localparam logic [IDX_W-1:0] IDX_CTRL   = 6'd2;

    localparam int unsigned NEW_BIT     = 0;
    localparam int unsigned OVR_BIT     = 1;
    localparam int unsigned OVR_CNT_LSB = 8;
    localparam int unsigned OVR_CNT_MSB = 15;
    localparam int unsigned FREEZE_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } state_t;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB address decode and IDLE/ACK/HOLD handshake.
// Registers the request on a hit and issues a single one-cycle ack per select.
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h01112200,
    parameter logic [31:0] HIGH_ADDR = 32'h011122FF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata_in,
    input  logic             rnw_in,
    input  logic             select,
    output logic             start,
    output logic [IDX_W-1:0] start_idx,
    output logic             ack,
    output logic [IDX_W-1:0] idx,
    output logic             rnw,
    output logic [31:0]      wdata
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             rnw_q;
    logic [31:0]      wdata_q;
    logic [31:0]      offset;
    logic             hit;
    logic             unused_offset;

    assign offset        = addr - BASE_ADDR;
    assign hit           = select && (addr >= BASE_ADDR) && (addr <= HIGH_ADDR);
    assign start         = (state_q == IDLE) && hit;
    assign start_idx     = offset[7:2];
    assign unused_offset = ^{offset[31:8], offset[1:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = HOLD;
            // Stay parked until the master drops select so a long select gets one ack.
            HOLD:    if (!select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rnw_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                idx_q   <= start_idx;
                rnw_q   <= rnw_in;
                wdata_q <= wdata_in;
            end
        end
    end

    assign ack   = (state_q == ACK);
    assign idx   = idx_q;
    assign rnw   = rnw_q;
    assign wdata = wdata_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave presenting a word captured from fabric logic to the PowerPC,
// with new/overrun status and a freeze control that blocks further captures.
module opb_register_simulink2ppc_snap
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01112200,
    parameter logic [31:0] C_HIGHADDR   = 32'h011122FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_freeze
);

    logic [31:0]      abus, dbus_in;
    logic             start, ack, rnw;
    logic [IDX_W-1:0] start_idx, idx;
    logic [31:0]      wdata;

    logic [31:0] data_q, data_d;
    logic        new_q, new_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  ovr_cnt_q, ovr_cnt_d;
    logic        freeze_q, freeze_d;
    logic [31:0] rdata_q, rdata_d;

    logic capture, clr_new, overrun, clr_ovr, wr_ctrl;
    logic unused_ok;

    // Bus bit 0 is the MSB, so a plain vector copy gives value bit n = bus bit [31-n].
    assign abus      = OPB_ABus;
    assign dbus_in   = OPB_DBus;
    assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata};

    opb_slave_ack_fsm #(
        .BASE_ADDR (C_BASEADDR),
        .HIGH_ADDR (C_HIGHADDR)
    ) u_fsm (
        .clk       (OPB_Clk),
        .rst_n     (OPB_Rst),
        .addr      (abus),
        .wdata_in  (dbus_in),
        .rnw_in    (OPB_RNW),
        .select    (OPB_select),
        .start     (start),
        .start_idx (start_idx),
        .ack       (ack),
        .idx       (idx),
        .rnw       (rnw),
        .wdata     (wdata)
    );

    assign capture = user_valid && !freeze_q;
    assign clr_new = ack && rnw && (idx == IDX_DATA);
    assign overrun = capture && new_q && !clr_new;
    assign clr_ovr = ack && !rnw && (idx == IDX_STATUS) && wdata[OVR_BIT];
    assign wr_ctrl = ack && !rnw && (idx == IDX_CTRL);

    always_comb begin
        data_d    = data_q;
        new_d     = new_q;
        ovr_d     = ovr_q;
        ovr_cnt_d = ovr_cnt_q;
        freeze_d  = freeze_q;

        if (capture) begin
            data_d = user_data_in;
            new_d  = 1'b1;
        end else if (clr_new) begin
            new_d = 1'b0;
        end

        // A clear that coincides with an overrun leaves exactly that one overrun recorded.
        if (clr_ovr) begin
            ovr_d     = overrun;
            ovr_cnt_d = overrun ? 8'd1 : 8'd0;
        end else if (overrun) begin
            ovr_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
        end

        if (wr_ctrl) freeze_d = wdata[FREEZE_BIT];
    end

    // Read data is snapshotted as the FSM enters ACK.
    always_comb begin
        rdata_d = '0;
        unique case (start_idx)
            IDX_DATA: rdata_d = data_q;
            IDX_STATUS: begin
                rdata_d[NEW_BIT]                 = new_q;
                rdata_d[OVR_BIT]                 = ovr_q;
                rdata_d[OVR_CNT_MSB:OVR_CNT_LSB] = ovr_cnt_q;
            end
            IDX_CTRL: rdata_d[FREEZE_BIT] = freeze_q;
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            data_q    <= '0;
            new_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
            freeze_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_q    <= data_d;
            new_q     <= new_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
            freeze_q  <= freeze_d;
            if (start) rdata_q <= rdata_d;
        end
    end

    assign Sl_DBus     = (ack && rnw) ? rdata_q : '0;
    assign Sl_xferAck  = ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_freeze = freeze_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench: stimulus pushes expected acks/read data into a scoreboard,
// a negedge monitor pops and compares whenever the slave acknowledges.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01112200;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b0;
    logic [0:31] OPB_ABus = '0;
    logic [0:3]  OPB_BE = 4'hF;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_RNW = 1'b0;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;
    logic        user_freeze;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_freeze  (user_freeze)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          issue;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   cyc     = 0;
    int   ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge OPB_Clk) cyc <= cyc + 1;

    always @(negedge OPB_Clk) begin : monitor
        exp_t e;
        if (OPB_Rst) begin
            if (Sl_xferAck) begin
                ack_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_latency"}, 32'(cyc - e.issue), 32'd1);
                    if (e.is_read) chk({e.name, "_rdata"}, Sl_DBus, e.data);
                end
            end else begin
                chk("dbus_idle_zero", Sl_DBus, 32'd0);
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                        input logic [31:0] exp, input int hold, input bit expect_ack,
                        input bit uv_ack, input logic [31:0] uv_data, input string name);
        int   a0;
        exp_t e;
        @(negedge OPB_Clk);
        a0 = ack_cnt;
        if (expect_ack) begin
            e.is_read = rnw;
            e.data    = exp;
            e.issue   = cyc;
            e.name    = name;
            sb.push_back(e);
        end
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_DBus   = wd;
        OPB_select = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge OPB_Clk);
            if (uv_ack && i == 0) begin
                user_valid   = 1'b1;
                user_data_in = uv_data;
            end
            if (uv_ack && i == 1) user_valid = 1'b0;
        end
        OPB_select = 1'b0;
        OPB_ABus   = '0;
        OPB_RNW    = 1'b0;
        OPB_DBus   = '0;
        @(negedge OPB_Clk);
        chk({name, "_ack_count"}, 32'(ack_cnt - a0), expect_ack ? 32'd1 : 32'd0);
        if (expect_ack && ack_cnt == a0 && sb.size() > 0) void'(sb.pop_back());
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        xfer(addr, 1'b1, 32'd0, exp, 2, 1'b1, 1'b0, 32'd0, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input string name);
        xfer(addr, 1'b0, wd, 32'd0, 2, 1'b1, 1'b0, 32'd0, name);
    endtask

    task automatic pulse(input logic [31:0] d);
        @(negedge OPB_Clk);
        user_valid   = 1'b1;
        user_data_in = d;
        @(negedge OPB_Clk);
        user_valid   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        repeat (3) @(negedge OPB_Clk);
        chk("rst_xferack", {31'd0, Sl_xferAck}, 32'd0);
        chk("rst_dbus", Sl_DBus, 32'd0);
        chk("rst_freeze", {31'd0, user_freeze}, 32'd0);
        chk("tieoffs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        OPB_Rst = 1'b1;

        rd(BASE + 32'h0, 32'h0, "rd_data_rst");
        rd(BASE + 32'h4, 32'h0, "rd_status_rst");
        rd(BASE + 32'h8, 32'h0, "rd_ctrl_rst");

        pulse(32'hDEADBEEF);
        rd(BASE + 32'h4, 32'h00000001, "status_new");
        rd(BASE + 32'h0, 32'hDEADBEEF, "data_beef");
        rd(BASE + 32'h4, 32'h00000000, "status_cleared");

        pulse(32'hA1);
        pulse(32'hA2);
        pulse(32'hA3);
        rd(BASE + 32'h4, 32'h00000203, "status_ovr2");
        wr(BASE + 32'h4, 32'h00000002, "wr_status_clr");
        rd(BASE + 32'h4, 32'h00000001, "status_after_clr");
        rd(BASE + 32'h0, 32'h000000A3, "data_a3");

        pulse(32'h11111111);
        xfer(BASE + 32'h0, 1'b1, 32'd0, 32'h11111111, 2, 1'b1, 1'b1, 32'h22222222,
             "data_coincide");
        rd(BASE + 32'h4, 32'h00000001, "status_set_wins");
        rd(BASE + 32'h0, 32'h22222222, "data_2222");

        chk("freeze_before", {31'd0, user_freeze}, 32'd0);
        wr(BASE + 32'h8, 32'h00000001, "wr_ctrl_freeze");
        chk("freeze_after", {31'd0, user_freeze}, 32'd1);
        pulse(32'h00000005);
        rd(BASE + 32'h4, 32'h00000000, "status_frozen");
        rd(BASE + 32'h0, 32'h22222222, "data_frozen");
        rd(BASE + 32'h8, 32'h00000001, "rd_ctrl");
        wr(BASE + 32'h8, 32'h00000000, "wr_ctrl_unfreeze");
        chk("freeze_cleared", {31'd0, user_freeze}, 32'd0);

        wr(BASE + 32'hC, 32'hFFFFFFFF, "wr_unmapped");
        rd(BASE + 32'hC, 32'h0, "rd_unmapped");
        rd(32'h011122FC, 32'h0, "rd_high_edge");
        xfer(32'h01112300, 1'b1, 32'd0, 32'd0, 2, 1'b0, 1'b0, 32'd0, "above_window");
        xfer(32'h011121FC, 1'b1, 32'd0, 32'd0, 2, 1'b0, 1'b0, 32'd0, "below_window");

        xfer(BASE + 32'h4, 1'b1, 32'd0, 32'h0, 5, 1'b1, 1'b0, 32'd0, "long_select");

        pulse(32'hCAFEF00D);
        wr(BASE + 32'h8, 32'h00000001, "wr_ctrl_pre_rst");
        @(negedge OPB_Clk);
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(posedge OPB_Clk);
        #1;
        chk("ack_before_rst", {31'd0, Sl_xferAck}, 32'd1);
        #1;
        OPB_Rst = 1'b0;
        #1;
        chk("ack_dropped_async", {31'd0, Sl_xferAck}, 32'd0);
        chk("dbus_rst_mid", Sl_DBus, 32'd0);
        chk("freeze_rst_mid", {31'd0, user_freeze}, 32'd0);
        @(negedge OPB_Clk);
        OPB_select = 1'b0;
        OPB_ABus   = '0;
        OPB_RNW    = 1'b0;
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        rd(BASE + 32'h0, 32'h0, "data_post_rst");
        rd(BASE + 32'h4, 32'h0, "status_post_rst");
        rd(BASE + 32'h8, 32'h0, "ctrl_post_rst");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
OPB slave that carries user data from fabric logic to the PowerPC. It is the reverse path of the PPC-to-Simulink software register.
- User logic presents a 32-bit word with a one-cycle valid strobe. The block latches the word and flags it as new.
- The PPC reads the latched word, a status word (new flag, overrun flag, overrun count) and a control word.
- User logic shares OPB_Clk; there is no second clock domain.

Parameters:
- C_BASEADDR, 32'h01112200, first byte address of the slave window.
- C_HIGHADDR, 32'h011122FF, last byte address of the slave window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex6", target family (passed through, no functional effect).

Ports:
- OPB_Clk  in  1  sole clock; user logic and the OPB bus both run on it.
- OPB_Rst  in  1  asynchronous, active-low reset.
- OPB_ABus  in  [0:31]  address bus.
- OPB_BE  in  [0:3]  byte enables; ignored, all accesses are full-word.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; all zero except during the ack cycle of a read.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_in  in  [31:0]  word from user logic.
- user_valid  in  1  capture strobe, one cycle per word.
- user_freeze  out  1  mirror of CTRL.freeze, for user logic.

Behaviour:
- Bit convention: value bit n maps to OPB bus bit [31-n].
- Address hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The word index is (OPB_ABus - C_BASEADDR)[7:2].
- Register map:
  - index 0, DATA (RO): latched word.
  - index 1, STATUS: bit0 NEW, bit1 OVR (sticky), bits15:8 OVR_CNT (saturates at 255), other bits 0.
  - index 2, CTRL (RW): bit0 freeze, other bits read 0.
  - Other indices: read 0, writes are acked and discarded.
- Reset (OPB_Rst=0, asynchronous):
  - All outputs are 0.
  - DATA, NEW, OVR, OVR_CNT and CTRL are 0.
  - FSM is in IDLE.
- Handshake FSM:
  - IDLE -> ACK on a hit. Address, RNW and write data are registered in the same cycle.
  - ACK: Sl_xferAck=1 for exactly one cycle. For reads, Sl_DBus carries the register value sampled at ACK entry. Then -> HOLD.
  - HOLD: stay while OPB_select=1, return to IDLE when OPB_select=0. No second ack is issued without a deselect.
  - Latency: ack arrives one cycle after the hit cycle.
  - Reset asserted mid-transfer drops the ack immediately; the FSM returns to IDLE.
- Capture:
  - user_valid=1 and freeze=0: DATA <= user_data_in, NEW <= 1.
  - If NEW was already 1 and is not being cleared that cycle: OVR <= 1, and OVR_CNT increments unless it is already 255.
  - While freeze=1, user_valid is ignored entirely (no capture, no overrun).
- Clearing:
  - The ACK cycle of a DATA read clears NEW.
  - If user_valid arrives in that same cycle, the set wins: NEW stays 1, the read returns the old word and no overrun is counted.
  - A STATUS write with value bit1=1 clears OVR and OVR_CNT. If an overrun event coincides, the result is OVR=1, OVR_CNT=1.
  - STATUS reads have no side effects.
- A CTRL write updates freeze in the ACK cycle; user_freeze follows on the next cycle.

Decomposition:
- Package opb_s2p_pkg holds:
  - word-index constants IDX_DATA=0, IDX_STATUS=1, IDX_CTRL=2;
  - bit positions NEW_BIT, OVR_BIT, OVR_CNT_LSB/MSB, FREEZE_BIT;
  - the FSM state enum {IDLE, ACK, HOLD}.
- Sub-module opb_slave_ack_fsm handles address decode and the IDLE/ACK/HOLD handshake. It outputs the registered index, RNW, write data and a one-cycle ack pulse.
- The top level holds the register file and the capture/clear logic.

Test Plan:
- Reset release, then read index 0 -> ack exactly 1 cycle after select, Sl_DBus=0, Sl_DBus=0 outside ack.
- user_valid with 0xDEADBEEF, then read STATUS -> 0x00000001. Read DATA -> 0xDEADBEEF. Read STATUS again -> 0x00000000.
- Three user_valid pulses with no read between them -> STATUS=0x00000203. Write STATUS 0x2 -> STATUS=0x00000001.
- user_valid 0x11111111, then a DATA read whose ack coincides with user_valid 0x22222222 -> read returns 0x11111111, NEW=1, OVR=0. Next DATA read -> 0x22222222.
- Write CTRL 0x1 -> user_freeze=1 next cycle; user_valid 0x5 ignored, DATA unchanged. Read CTRL -> 0x00000001.
- OPB_select held 5 cycles -> exactly one ack. Assert reset during ACK -> Sl_xferAck drops asynchronously and all registers read 0 afterwards.
